// File: rtl/bellek_istemcisi_pkg.sv
// Shared definitions for the main-memory initiator and the cache controller:
// bus widths, block-alignment mask and state encodings.
package bellek_istemcisi_pkg;

  localparam int unsigned ADRES_W = 32;
  localparam int unsigned BLOK_W  = 256;
  localparam int unsigned SAYAC_W = 16;

  localparam logic [ADRES_W-1:0] OBEK_MASKESI = 32'hFFFF_FFE0;

  typedef enum logic [2:0] {
    BOSTA       = 3'd0,
    YAZ_ISTEK   = 3'd1,
    OKU_ISTEK   = 3'd2,
    YANIT_BEKLE = 3'd3,
    DOLUM       = 3'd4,
    HATA        = 3'd5
  } durum_e;

  function automatic logic [ADRES_W-1:0] obek_hizala(input logic [ADRES_W-1:0] adres);
    return adres & OBEK_MASKESI;
  endfunction

endpackage

// File: rtl/bellek_istemcisi_zaman_asimi_sayaci.sv
// Watchdog counter for memory-wait states: clears on request, counts while
// enabled, and flags when the count reaches the configured limit.
module bellek_istemcisi_zaman_asimi_sayaci
  import bellek_istemcisi_pkg::*;
#(
  parameter logic [SAYAC_W-1:0] SINIR = 16'd255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic temizle_i,
  input  logic sayac_etkin_i,
  output logic sinir_o
);

  logic [SAYAC_W-1:0] sayac_q, sayac_d;

  always_comb begin
    sayac_d = sayac_q;
    if (temizle_i) begin
      sayac_d = '0;
    end else if (sayac_etkin_i) begin
      sayac_d = sayac_q + SAYAC_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sayac_q <= '0;
    end else begin
      sayac_q <= sayac_d;
    end
  end

  assign sinir_o = (sayac_q == SINIR);

endmodule

// File: rtl/bellek_istemcisi.sv
// Main-memory initiator: one cache miss at a time, optional dirty write-back,
// block read, fill return; every memory wait is guarded by a watchdog.
module bellek_istemcisi
  import bellek_istemcisi_pkg::*;
#(
  parameter int unsigned ZAMAN_ASIMI = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 talep_gecerli_i,
  output logic                 talep_hazir_o,
  input  logic [ADRES_W-1:0]   talep_adres_i,
  input  logic                 talep_kirli_i,
  input  logic [ADRES_W-1:0]   talep_kurban_adres_i,
  input  logic [BLOK_W-1:0]    talep_kurban_veri_i,
  output logic [BLOK_W-1:0]    dolum_veri_o,
  output logic                 dolum_gecerli_o,
  input  logic                 dolum_hazir_i,
  output logic [ADRES_W-1:0]   istek_adres_o,
  output logic [BLOK_W-1:0]    istek_veri_o,
  output logic                 istek_gecerli_o,
  output logic                 istek_yaz_gecerli_o,
  input  logic                 istek_hazir_i,
  input  logic [BLOK_W-1:0]    yanit_veri_i,
  input  logic                 yanit_gecerli_i,
  output logic                 yanit_hazir_o,
  output logic                 hata_o
);

  durum_e durum_q, durum_d;

  logic               talep_hazir_q, talep_hazir_d;
  logic               istek_gecerli_q, istek_gecerli_d;
  logic               istek_yaz_q, istek_yaz_d;
  logic               yanit_hazir_q, yanit_hazir_d;
  logic               dolum_gecerli_q, dolum_gecerli_d;
  logic               hata_q, hata_d;
  logic [ADRES_W-1:0] istek_adres_q, istek_adres_d;
  logic [ADRES_W-1:0] dolum_adres_q, dolum_adres_d;
  logic [BLOK_W-1:0]  istek_veri_q, istek_veri_d;
  logic [BLOK_W-1:0]  dolum_veri_q, dolum_veri_d;

  logic talep_al;
  logic bekleme_durumu;
  logic sayac_temizle;
  logic zaman_doldu;

  assign talep_al       = (durum_q == BOSTA) && talep_gecerli_i && talep_hazir_q;
  assign bekleme_durumu = (durum_q == YAZ_ISTEK) || (durum_q == OKU_ISTEK) ||
                          (durum_q == YANIT_BEKLE);
  assign sayac_temizle  = (durum_d != durum_q) || !bekleme_durumu;

  bellek_istemcisi_zaman_asimi_sayaci #(
    .SINIR(SAYAC_W'(ZAMAN_ASIMI))
  ) u_zaman_asimi_sayaci (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .temizle_i    (sayac_temizle),
    .sayac_etkin_i(bekleme_durumu),
    .sinir_o      (zaman_doldu)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum_q         <= BOSTA;
      talep_hazir_q   <= 1'b0;
      istek_gecerli_q <= 1'b0;
      istek_yaz_q     <= 1'b0;
      yanit_hazir_q   <= 1'b0;
      dolum_gecerli_q <= 1'b0;
      hata_q          <= 1'b0;
      istek_adres_q   <= '0;
      dolum_adres_q   <= '0;
      istek_veri_q    <= '0;
      dolum_veri_q    <= '0;
    end else begin
      durum_q         <= durum_d;
      talep_hazir_q   <= talep_hazir_d;
      istek_gecerli_q <= istek_gecerli_d;
      istek_yaz_q     <= istek_yaz_d;
      yanit_hazir_q   <= yanit_hazir_d;
      dolum_gecerli_q <= dolum_gecerli_d;
      hata_q          <= hata_d;
      istek_adres_q   <= istek_adres_d;
      dolum_adres_q   <= dolum_adres_d;
      istek_veri_q    <= istek_veri_d;
      dolum_veri_q    <= dolum_veri_d;
    end
  end

  // A transfer on the limit edge takes priority over the timeout.
  always_comb begin
    durum_d = durum_q;
    unique case (durum_q)
      BOSTA:       if (talep_al) durum_d = talep_kirli_i ? YAZ_ISTEK : OKU_ISTEK;
      YAZ_ISTEK:   if (istek_hazir_i) durum_d = OKU_ISTEK;
                   else if (zaman_doldu) durum_d = HATA;
      OKU_ISTEK:   if (istek_hazir_i) durum_d = YANIT_BEKLE;
                   else if (zaman_doldu) durum_d = HATA;
      YANIT_BEKLE: if (yanit_gecerli_i) durum_d = DOLUM;
                   else if (zaman_doldu) durum_d = HATA;
      DOLUM:       if (dolum_hazir_i) durum_d = BOSTA;
      HATA:        durum_d = HATA;
      default:     durum_d = HATA;
    endcase
  end

  // Output registers follow the next state so they are valid on state entry.
  always_comb begin
    talep_hazir_d   = (durum_d == BOSTA);
    istek_gecerli_d = (durum_d == YAZ_ISTEK) || (durum_d == OKU_ISTEK);
    istek_yaz_d     = (durum_d == YAZ_ISTEK);
    yanit_hazir_d   = (durum_d == YANIT_BEKLE);
    dolum_gecerli_d = (durum_d == DOLUM);
    hata_d          = (durum_d == HATA);
    istek_adres_d   = istek_adres_q;
    istek_veri_d    = istek_veri_q;
    dolum_adres_d   = dolum_adres_q;
    dolum_veri_d    = dolum_veri_q;
    if (talep_al) begin
      dolum_adres_d = obek_hizala(talep_adres_i);
      istek_adres_d = talep_kirli_i ? obek_hizala(talep_kurban_adres_i)
                                    : obek_hizala(talep_adres_i);
      istek_veri_d  = talep_kirli_i ? talep_kurban_veri_i : '0;
    end
    if ((durum_q == YAZ_ISTEK) && (durum_d == OKU_ISTEK)) begin
      istek_adres_d = dolum_adres_q;
      istek_veri_d  = '0;
    end
    if ((durum_q == YANIT_BEKLE) && (durum_d == DOLUM)) begin
      dolum_veri_d = yanit_veri_i;
    end
    if (!istek_gecerli_d) begin
      istek_adres_d = '0;
      istek_veri_d  = '0;
    end
  end

  assign talep_hazir_o       = talep_hazir_q;
  assign istek_gecerli_o     = istek_gecerli_q;
  assign istek_yaz_gecerli_o = istek_yaz_q;
  assign yanit_hazir_o       = yanit_hazir_q;
  assign dolum_gecerli_o     = dolum_gecerli_q;
  assign hata_o              = hata_q;
  assign istek_adres_o       = istek_adres_q;
  assign istek_veri_o        = istek_veri_q;
  assign dolum_veri_o        = dolum_veri_q;

endmodule

// File: doc/bellek_istemcisi.md
Name: bellek_istemcisi

Overview:
Initiator end of the main-memory request/response interface, sitting between the cache controller and main memory.
- Takes one cache miss at a time from the controller.
- If the victim line is dirty, issues a 256-bit block write-back first.
- Then issues the 256-bit block read, returns the fill line to the controller, and guards every memory wait with a watchdog.

Parameters:
ZAMAN_ASIMI, 255, max cycles spent in any single memory-wait state before the error trap; legal range 1..65535.
OBEK_MASKESI, 32'hFFFF_FFE0, block-alignment mask applied to every outgoing address (32-byte blocks).

Ports:
clk_i  input  1  clock, all state on rising edge.
rst_i  input  1  reset, asynchronous, active-high.
talep_gecerli_i  input  1  controller has a miss request.
talep_hazir_o  output  1  block can accept a miss request.
talep_adres_i  input  32  miss (fill) byte address.
talep_kirli_i  input  1  victim line dirty, write-back required.
talep_kurban_adres_i  input  32  victim byte address.
talep_kurban_veri_i  input  256  victim line data, byte k at bits [8k+7:8k].
dolum_veri_o  output  256  fill line returned to controller.
dolum_gecerli_o  output  1  fill line valid.
dolum_hazir_i  input  1  controller accepts fill line.
istek_adres_o  output  32  memory request address, block-aligned.
istek_veri_o  output  256  memory write data.
istek_gecerli_o  output  1  memory request valid.
istek_yaz_gecerli_o  output  1  1 = write, 0 = read.
istek_hazir_i  input  1  memory accepts request.
yanit_veri_i  input  256  memory read data.
yanit_gecerli_i  input  1  memory read data valid.
yanit_hazir_o  output  1  block accepts read data.
hata_o  output  1  sticky watchdog error.

Behaviour:
- One clock; reset is asynchronous and active-high.
- While rst_i is high, all outputs are 0, the state is BOSTA and the watchdog is 0.
- Reset mid-operation abandons any transfer immediately.
- Outputs are registered or decoded from the state register only; no combinational input-to-output path.
- A transfer occurs on a rising edge where valid and ready are both 1.

States:
- BOSTA: talep_hazir_o=1 from the first cycle after reset deasserts.
  - On talep transfer, latch fill address, victim address, victim data and the dirty flag.
  - Next state is YAZ_ISTEK if talep_kirli_i=1, else OKU_ISTEK.
- YAZ_ISTEK: istek_gecerli_o=1, istek_yaz_gecerli_o=1, istek_adres_o = victim address & OBEK_MASKESI, istek_veri_o = victim data.
  - On istek transfer, go to OKU_ISTEK.
  - A write produces no response; the next request simply waits for istek_hazir_i.
- OKU_ISTEK: istek_gecerli_o=1, istek_yaz_gecerli_o=0, istek_adres_o = fill address & OBEK_MASKESI, istek_veri_o=0.
  - On istek transfer, go to YANIT_BEKLE.
- YANIT_BEKLE: yanit_hazir_o=1.
  - On yanit transfer, latch yanit_veri_i into dolum_veri_o and go to DOLUM.
- DOLUM: dolum_gecerli_o=1, dolum_veri_o held stable.
  - On dolum transfer, go to BOSTA; talep_hazir_o is 1 the next cycle.
- HATA: all valid/ready outputs 0, hata_o=1. Left only by reset.

Handshake rules:
- Once istek_gecerli_o or dolum_gecerli_o is asserted, it and its address/data stay stable until the transfer.
- istek_gecerli_o drops in the cycle after the transfer edge.

Watchdog:
- 16-bit counter, cleared on every state change and in BOSTA and DOLUM.
- Increments each cycle in YAZ_ISTEK, OKU_ISTEK and YANIT_BEKLE.
- When the counter equals ZAMAN_ASIMI with no transfer that edge, go to HATA.
- If a transfer and the limit coincide on the same edge, the transfer wins.
- DOLUM has no timeout; controller backpressure is unbounded.

Latency:
- Minimum 1 cycle from talep transfer to istek_gecerli_o.
- Fill data appears on dolum_veri_o the cycle after the yanit transfer.
- Against the 100-cycle memory, a clean miss takes about 104 cycles and a dirty miss about 207.

Decomposition:
- Shared package: state encodings (BOSTA..HATA, 3 bits), OBEK_MASKESI, block width 256, address width 32.
- Shared because the cache controller FSM reuses the widths and mask.
- One sub-module is natural: zaman_asimi_sayaci (clear/enable inputs, limit-reached output).

Test Plan:
- Clean miss against the existing 100-cycle memory model, preloaded 0x120..0x13F with bytes 0x00..0x1F.
  - Stimulus: talep_adres_i=0x0000_0124, kirli=0.
  - Required: exactly one memory read, at 0x0000_0120; dolum_veri_o[7:0]=0x00 and [255:248]=0x1F; no write seen.
- Dirty miss: kurban_adres=0x0000_0047, kurban_veri=256'hA5 repeated, adres=0x0000_0040.
  - Required: write to 0x40, then read of 0x40.
  - Fill data is all bytes 0xA5 (read-after-write ordering proven).
- Backpressure: hold dolum_hazir_i=0 for 5 cycles after dolum_gecerli_o rises.
  - Required: dolum_gecerli_o and dolum_veri_o stable for all 5 cycles.
  - talep_hazir_o=0 until the cycle after the transfer.
- Timeout: ZAMAN_ASIMI=20, memory stub holds istek_hazir_i=0.
  - Required: hata_o=1 exactly 21 cycles after entering OKU_ISTEK; talep_hazir_o stays 0 until reset.
- Reset mid-YANIT_BEKLE: assert rst_i asynchronously 50 cycles into the wait.
  - Required: all outputs 0 without waiting for a clock edge.
  - After release, talep_hazir_o=1 one cycle later and a fresh clean miss completes correctly.
- Back-to-back: issue a second talep in the same cycle the first dolum transfer completes.
  - Required: it is not accepted until BOSTA (one cycle later), and both fills return correct data in order.
